// File: rtl/cvxif_copro_pkg.sv
// Shared constants and types for the CV-X-IF coprocessor responder
// and its in-flight entry queue.
package cvxif_copro_pkg;

    localparam int TRANS_ID_BITS = 3;
    localparam int COPRO_XLEN    = 64;
    localparam int CNT_BITS      = 8;

    localparam logic [6:0] CUS_OPCODE  = 7'h7B;
    localparam logic [5:0] EXC_ILLEGAL = 6'd2;

    typedef enum logic [1:0] {
        CUS_NOP  = 2'd0,
        CUS_ADD  = 2'd1,
        CUS_ADDM = 2'd2,
        CUS_EXC  = 2'd3
    } copro_op_e;

    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] id;
        logic [4:0]               rd;
        logic [COPRO_XLEN-1:0]    data;
        logic                     we;
        logic                     exc;
        logic [CNT_BITS-1:0]      cnt;
        logic                     committed;
        logic                     killed;
    } copro_entry_t;

    function automatic logic op_adds(input copro_op_e op);
        return (op == CUS_ADD) || (op == CUS_ADDM);
    endfunction

    // Cycles an entry must wait before it may be emitted.
    function automatic logic [CNT_BITS-1:0] op_delay(
        input copro_op_e op,
        input int        lat
    );
        return (op == CUS_ADDM) ? CNT_BITS'(lat - 1) : '0;
    endfunction

endpackage

// File: rtl/cvxif_copro_entry_q.sv
// In-flight entry queue: circular buffer with per-entry countdown and
// id-matched commit/kill marking.
module cvxif_copro_entry_q
    import cvxif_copro_pkg::*;
#(
    parameter int Depth = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  copro_entry_t             push_entry_i,
    input  logic                     pop_i,
    input  logic                     commit_valid_i,
    input  logic [TRANS_ID_BITS-1:0] commit_id_i,
    input  logic                     commit_kill_i,
    output copro_entry_t             head_o,
    output logic                     head_valid_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int PtrW = $clog2(Depth);

    copro_entry_t     mem [Depth];
    logic [Depth-1:0] vld;
    logic [PtrW-1:0]  head;
    logic [PtrW-1:0]  tail;
    logic [PtrW:0]    count;
    logic [Depth-1:0] hit;
    copro_entry_t     push_entry;

    // A commit aimed at the id being issued lands on the new entry.
    always_comb begin
        push_entry = push_entry_i;
        if (commit_valid_i && (commit_id_i == push_entry_i.id)) begin
            push_entry.committed = ~commit_kill_i;
            push_entry.killed    = commit_kill_i;
        end
    end

    always_comb begin
        hit = '0;
        for (int i = 0; i < Depth; i++) begin
            hit[i] = vld[i] & commit_valid_i
                   & (mem[i].id == commit_id_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            vld   <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else if (clr_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            vld   <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < Depth; i++) begin
                if (vld[i]) begin
                    if (mem[i].cnt != '0) begin
                        mem[i].cnt <= mem[i].cnt - CNT_BITS'(1);
                    end
                    if (hit[i]) begin
                        if (commit_kill_i) begin
                            mem[i].killed <= 1'b1;
                        end else begin
                            mem[i].committed <= 1'b1;
                        end
                    end
                end
            end
            if (pop_i) begin
                vld[head] <= 1'b0;
                head      <= head + PtrW'(1);
            end
            if (push_i) begin
                mem[tail] <= push_entry;
                vld[tail] <= 1'b1;
                tail      <= tail + PtrW'(1);
            end
            count <= count
                   + {{PtrW{1'b0}}, push_i}
                   - {{PtrW{1'b0}}, pop_i};
        end
    end

    assign head_o       = mem[head];
    assign head_valid_o = vld[head];
    assign count_o      = count;

endmodule

// File: rtl/cvxif_copro_responder.sv
// CV-X-IF responder: decodes custom-3 ops, executes speculatively and
// returns committed results in issue order.
module cvxif_copro_responder
    import cvxif_copro_pkg::*;
#(
    parameter int IdWidth  = TRANS_ID_BITS,
    parameter int XLEN     = COPRO_XLEN,
    parameter int Depth    = 4,
    parameter int MultiLat = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clr_i,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [31:0]         issue_instr_i,
    input  logic [IdWidth-1:0]  issue_id_i,
    input  logic [2*XLEN-1:0]   issue_rs_i,
    input  logic [1:0]          issue_rs_valid_i,
    output logic                issue_accept_o,
    output logic                issue_writeback_o,
    input  logic                commit_valid_i,
    input  logic [IdWidth-1:0]  commit_id_i,
    input  logic                commit_kill_i,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [IdWidth-1:0]  result_id_o,
    output logic [XLEN-1:0]     result_data_o,
    output logic [4:0]          result_rd_o,
    output logic                result_we_o,
    output logic                result_exc_o,
    output logic [5:0]          result_exccode_o
);

    localparam int CntW = $clog2(Depth) + 1;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    copro_op_e       op;
    logic            legal;
    logic [1:0]      rs_need;
    logic            operands_ok;
    logic            handshake;
    logic            push;
    logic            pop;
    copro_entry_t    new_entry;
    copro_entry_t    head;
    logic            head_valid;
    logic [CntW-1:0] count;
    logic            unused_instr;

    assign opcode       = issue_instr_i[6:0];
    assign rd           = issue_instr_i[11:7];
    assign funct3       = issue_instr_i[14:12];
    assign rs1          = issue_rs_i[XLEN-1:0];
    assign rs2          = issue_rs_i[2*XLEN-1:XLEN];
    assign unused_instr = ^issue_instr_i[31:15];

    always_comb begin
        legal   = 1'b0;
        op      = CUS_NOP;
        rs_need = 2'b00;
        if (opcode == CUS_OPCODE) begin
            unique case (funct3)
                3'd0: begin
                    legal = 1'b1;
                    op    = CUS_NOP;
                end
                3'd1: begin
                    legal   = 1'b1;
                    op      = CUS_ADD;
                    rs_need = 2'b11;
                end
                3'd2: begin
                    legal   = 1'b1;
                    op      = CUS_ADDM;
                    rs_need = 2'b11;
                end
                3'd3: begin
                    legal = 1'b1;
                    op    = CUS_EXC;
                end
                default: legal = 1'b0;
            endcase
        end
    end

    assign operands_ok = (issue_rs_valid_i & rs_need) == rs_need;

    // Readiness looks only at the registered count; a same-cycle pop
    // does not open a slot.
    assign issue_ready_o     = ~rst_i & (count < CntW'(Depth));
    assign handshake         = issue_valid_i & issue_ready_o;
    assign issue_accept_o    = handshake & legal & operands_ok;
    assign issue_writeback_o = issue_accept_o & op_adds(op)
                             & (rd != 5'd0);
    assign push              = issue_accept_o;

    always_comb begin
        new_entry     = '0;
        new_entry.id  = issue_id_i;
        new_entry.rd  = rd;
        new_entry.exc = (op == CUS_EXC);
        new_entry.cnt = op_delay(op, MultiLat);
        if (op_adds(op)) begin
            new_entry.data = rs1 + rs2;
            new_entry.we   = (rd != 5'd0);
        end
    end

    cvxif_copro_entry_q #(
        .Depth (Depth)
    ) u_entry_q (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .clr_i          (clr_i),
        .push_i         (push),
        .push_entry_i   (new_entry),
        .pop_i          (pop),
        .commit_valid_i (commit_valid_i),
        .commit_id_i    (commit_id_i),
        .commit_kill_i  (commit_kill_i),
        .head_o         (head),
        .head_valid_o   (head_valid),
        .count_o        (count)
    );

    assign result_valid_o = head_valid & head.committed
                          & ~head.killed & (head.cnt == '0);

    // Killed heads leave without a handshake.
    assign pop = (result_valid_o & result_ready_i)
               | (head_valid & head.killed);

    assign result_id_o      = result_valid_o ? head.id   : '0;
    assign result_data_o    = result_valid_o ? head.data : '0;
    assign result_rd_o      = result_valid_o ? head.rd   : '0;
    assign result_we_o      = result_valid_o & head.we;
    assign result_exc_o     = result_valid_o & head.exc;
    assign result_exccode_o = (result_valid_o & head.exc)
                            ? EXC_ILLEGAL : 6'd0;

endmodule
